// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU data port, loader/debug master),
// the shared single-ported data memory, and dmem_arbiter.
// slave  : arbiter side (takes requests and read data, drives grants and the memory strobe)
// master : environment side (requesters and memory model)
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // CPU data port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    // Loader / debug master
    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_lock;
    logic          ldr_gnt;
    logic          ldr_rvalid;
    logic [DW-1:0] ldr_rdata;

    // Shared memory
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported synchronous data memory between the
// CPU data port and a loader/debug master. One access per cycle, bounded-burst
// fair arbitration (MAX_BURST consecutive grants while the other side waits),
// and an exclusive loader lock that shuts the CPU out until released.
// Grants are combinational from registered state and the live requests; read
// data returns one cycle after the grant and is steered to the requester that
// issued it.
// Optional build macro ARB_STATS_EN adds saturating grant/conflict counters
// with a synchronous stats_clr input.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   cpu_grant_cnt,
    output logic [15:0]   ldr_grant_cnt,
    output logic [15:0]   conflict_cnt
`endif
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    owner_t        owner_reg, owner_next, winner;
    logic [3:0]    burst_cnt_reg, burst_cnt_next;
    logic          locked_reg;
    logic          rd_pend_cpu_reg, rd_pend_ldr_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;

    logic          cpu_win, ldr_win;
    logic          cpu_gnt_int, ldr_gnt_int, mem_en_int;
    logic [AW-1:0] mem_addr_int;
    logic [DW-1:0] mem_wdata_int;

    // Winner selection: lock first, then lone requester, then burst fairness,
    // with the loader taking a contested cycle when nobody owns the bus.
    always_comb begin
        cpu_win = 1'b0;
        ldr_win = 1'b0;
        if (locked_reg) begin
            ldr_win = bus.ldr_req;
        end else if (bus.cpu_req && !bus.ldr_req) begin
            cpu_win = 1'b1;
        end else if (!bus.cpu_req && bus.ldr_req) begin
            ldr_win = 1'b1;
        end else if (bus.cpu_req && bus.ldr_req) begin
            case (owner_reg)
                OWN_CPU: begin
                    if (burst_cnt_reg < MAX_B) cpu_win = 1'b1;
                    else                       ldr_win = 1'b1;
                end
                OWN_LDR: begin
                    if (burst_cnt_reg < MAX_B) ldr_win = 1'b1;
                    else                       cpu_win = 1'b1;
                end
                default: ldr_win = 1'b1;
            endcase
        end
    end

    // Reset masks every strobe so nothing reaches the memory while it is held.
    assign cpu_gnt_int = cpu_win & ~reset;
    assign ldr_gnt_int = ldr_win & ~reset;
    assign mem_en_int  = cpu_gnt_int | ldr_gnt_int;

    // Ownership / burst bookkeeping: same owner extends the burst (saturating),
    // a new winner restarts it at 1, an idle cycle releases the bus.
    always_comb begin
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        winner         = cpu_win ? OWN_CPU : OWN_LDR;
        if (cpu_win || ldr_win) begin
            if (winner == owner_reg) begin
                burst_cnt_next = (burst_cnt_reg >= MAX_B) ? MAX_B : burst_cnt_reg + 4'd1;
            end else begin
                owner_next     = winner;
                burst_cnt_next = 4'd1;
            end
        end else begin
            owner_next     = OWN_IDLE;
            burst_cnt_next = 4'd0;
        end
    end

    // Memory address/data mux: winner's inputs on a grant, otherwise hold the
    // last issued values so the memory pins do not toggle on idle cycles.
    always_comb begin
        mem_addr_int  = mem_addr_reg;
        mem_wdata_int = mem_wdata_reg;
        if (cpu_win) begin
            mem_addr_int  = bus.cpu_addr;
            mem_wdata_int = bus.cpu_wdata;
        end else if (ldr_win) begin
            mem_addr_int  = bus.ldr_addr;
            mem_wdata_int = bus.ldr_wdata;
        end
    end

    // Arbitration state, lock flag, read-return tracking and held memory bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg       <= OWN_IDLE;
            burst_cnt_reg   <= 4'd0;
            locked_reg      <= 1'b0;
            rd_pend_cpu_reg <= 1'b0;
            rd_pend_ldr_reg <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
        end else begin
            owner_reg       <= owner_next;
            burst_cnt_reg   <= burst_cnt_next;
            locked_reg      <= bus.ldr_lock;
            rd_pend_cpu_reg <= cpu_gnt_int & ~bus.cpu_we;
            rd_pend_ldr_reg <= ldr_gnt_int & ~bus.ldr_we;
            if (mem_en_int) begin
                mem_addr_reg  <= mem_addr_int;
                mem_wdata_reg <= mem_wdata_int;
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_int;
    assign bus.ldr_gnt    = ldr_gnt_int;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt_int;
    assign bus.mem_en     = mem_en_int;
    assign bus.mem_we     = (cpu_gnt_int & bus.cpu_we) | (ldr_gnt_int & bus.ldr_we);
    assign bus.mem_addr   = reset ? '0 : mem_addr_int;
    assign bus.mem_wdata  = reset ? '0 : mem_wdata_int;

    // Read data is shared by both ports but only visible to the one that asked.
    assign bus.cpu_rvalid = rd_pend_cpu_reg;
    assign bus.ldr_rvalid = rd_pend_ldr_reg;
    assign bus.cpu_rdata  = rd_pend_cpu_reg ? bus.mem_rdata : '0;
    assign bus.ldr_rdata  = rd_pend_ldr_reg ? bus.mem_rdata : '0;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_grant_cnt_reg, ldr_grant_cnt_reg, conflict_cnt_reg;

    // Saturating activity counters; a clear request overrides counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_grant_cnt_reg <= 16'd0;
            ldr_grant_cnt_reg <= 16'd0;
            conflict_cnt_reg  <= 16'd0;
        end else if (stats_clr) begin
            cpu_grant_cnt_reg <= 16'd0;
            ldr_grant_cnt_reg <= 16'd0;
            conflict_cnt_reg  <= 16'd0;
        end else begin
            if (cpu_gnt_int && cpu_grant_cnt_reg != 16'hFFFF)
                cpu_grant_cnt_reg <= cpu_grant_cnt_reg + 16'd1;
            if (ldr_gnt_int && ldr_grant_cnt_reg != 16'hFFFF)
                ldr_grant_cnt_reg <= ldr_grant_cnt_reg + 16'd1;
            if (bus.cpu_req && bus.ldr_req && conflict_cnt_reg != 16'hFFFF)
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign cpu_grant_cnt = cpu_grant_cnt_reg;
    assign ldr_grant_cnt = ldr_grant_cnt_reg;
    assign conflict_cnt  = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed stimulus with per-cycle grant
// expectations, a small memory model, and a read scoreboard (expected read
// data pushed at grant time, popped when the matching rvalid cycle arrives).
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cpu_grant_cnt, ldr_grant_cnt, conflict_cnt;
`endif

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .cpu_grant_cnt (cpu_grant_cnt),
        .ldr_grant_cnt (ldr_grant_cnt),
        .conflict_cnt  (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model seen by the arbiter, and the bench's own expected contents.
    logic [31:0] mem_model [256];
    logic [31:0] shadow    [256];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_model[bus.mem_addr[9:2]];
        end
    end

    typedef struct {
        bit          to_cpu;
        logic [31:0] data;
        int          due;
    } rd_t;
    rd_t sb[$];

    logic [31:0] last_addr, last_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read-return monitor: every cycle, each port's rvalid/rdata must match the scoreboard.
    bit          mon_c, mon_l;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        mon_c = 1'b0;
        mon_l = 1'b0;
        mon_d = 32'd0;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            if (sb[0].due < cyc) chk("rd_due_late", 32'(sb[0].due), 32'(cyc));
            mon_c = sb[0].to_cpu;
            mon_l = !sb[0].to_cpu;
            mon_d = sb[0].data;
            void'(sb.pop_front());
        end
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(mon_c));
        chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(mon_l));
        chk("cpu_rdata",  bus.cpu_rdata, mon_c ? mon_d : 32'd0);
        chk("ldr_rdata",  bus.ldr_rdata, mon_l ? mon_d : 32'd0);
        $display("cyc=%0d cpu_gnt=%0b ldr_gnt=%0b stall=%0b mem_en=%0b we=%0b addr=%h cpu_rv=%0b ldr_rv=%0b",
                 cyc, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_stall, bus.mem_en, bus.mem_we,
                 bus.mem_addr, bus.cpu_rvalid, bus.ldr_rvalid);
    end

    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                         input bit lk);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ldr_req   = lr;
        bus.ldr_we    = lw;
        bus.ldr_addr  = la;
        bus.ldr_wdata = ld;
        bus.ldr_lock  = lk;
    endtask

    task automatic drive_idle();
        drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
    endtask

    // Compare grant-side outputs against the bench's expected winner; record reads/writes.
    task automatic check_cycle(input bit eg_c, input bit eg_l);
        logic [31:0] wa, wd;
        bit          ww;
        chk("cpu_gnt",   32'(bus.cpu_gnt),   32'(eg_c));
        chk("ldr_gnt",   32'(bus.ldr_gnt),   32'(eg_l));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~eg_c));
        chk("mem_en",    32'(bus.mem_en),    32'(eg_c | eg_l));
        if (eg_c || eg_l) begin
            ww = eg_c ? bus.cpu_we    : bus.ldr_we;
            wa = eg_c ? bus.cpu_addr  : bus.ldr_addr;
            wd = eg_c ? bus.cpu_wdata : bus.ldr_wdata;
            chk("mem_we",    32'(bus.mem_we), 32'(ww));
            chk("mem_addr",  bus.mem_addr,  wa);
            chk("mem_wdata", bus.mem_wdata, wd);
            if (ww) shadow[wa[9:2]] = wd;
            else    sb.push_back('{eg_c, shadow[wa[9:2]], cyc + 1});
            last_addr  = wa;
            last_wdata = wd;
        end else begin
            chk("mem_we_idle",    32'(bus.mem_we), 32'd0);
            chk("mem_addr_hold",  bus.mem_addr,  last_addr);
            chk("mem_wdata_hold", bus.mem_wdata, last_wdata);
        end
    endtask

    task automatic step(input bit eg_c, input bit eg_l);
        @(negedge clk);
        check_cycle(eg_c, eg_l);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_gnt",   32'(bus.cpu_gnt), 32'd0);
        chk("rst_ldr_gnt",   32'(bus.ldr_gnt), 32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),  32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),  32'd0);
        chk("rst_mem_addr",  bus.mem_addr,  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
`ifdef ARB_STATS_EN
        chk("rst_conflict",  32'(conflict_cnt), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 32'hC0DE0000 | 32'(i);
            shadow[i]    = 32'hC0DE0000 | 32'(i);
        end
        mem_model[4] = 32'hDEADBEEF;
        shadow[4]    = 32'hDEADBEEF;
        bus.mem_rdata = 32'd0;
        last_addr  = 32'd0;
        last_wdata = 32'd0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        reset = 1'b1;
        drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0, 0);

        // Reset: requests present but nothing may be issued.
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        step(0, 0);

        // CPU only read of 0x10.
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0);
        drive_idle();
        step(0, 0);

        // CPU alone beyond MAX_BURST keeps winning.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h20 + 32'(4 * i), 32'h0, 0, 0, 32'h0, 32'h0, 0);
            step(1, 0);
        end
        drive_idle();
        step(0, 0);

        // Both requesting from IDLE: L,L,L,L,C,C,C,C,L,L,L,L.
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0, 0);
            step(((k / 4) % 2) == 1, ((k / 4) % 2) == 0);
        end
        drive_idle();
        step(0, 0);

        // Locked loader writes 0x00..0x1C while the CPU keeps requesting.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'h40, 32'h0, 1, 1, 32'(4 * i), 32'h10000000 + 32'(i), 1);
            step(0, 1);
        end
        drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0);
        step(1, 0);
        drive_idle();
        step(0, 0);

        // Alternating single reads; also reads back words the loader wrote.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0, 0);
            step(1, 0);
            drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0, 0);
            step(0, 1);
        end
        drive_idle();
        step(0, 0);

        // Reset one cycle after a CPU read grant: the return is dropped.
        drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        last_addr  = 32'd0;
        last_wdata = 32'd0;
        // Owner is IDLE again, so the loader takes a contested first cycle.
        drive(1, 0, 32'h14, 32'h0, 1, 0, 32'h18, 32'h0, 0);
        step(0, 1);
        drive(1, 0, 32'h1C, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0);
        drive_idle();
        step(0, 0);

`ifdef ARB_STATS_EN
        stats_clr = 1'b1;
        step(0, 0);
        stats_clr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0, 0);
            step(((k / 4) % 2) == 1, ((k / 4) % 2) == 0);
        end
        drive_idle();
        stats_clr = 1'b1;
        @(negedge clk);
        check_cycle(0, 0);
        chk("conflict_cnt",  32'(conflict_cnt), 32'd10);
        chk("grant_sum",     32'(cpu_grant_cnt) + 32'(ldr_grant_cnt), 32'd10);
        chk("cpu_grant_cnt", 32'(cpu_grant_cnt), 32'd4);
        chk("ldr_grant_cnt", 32'(ldr_grant_cnt), 32'd6);
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check_cycle(0, 0);
        chk("clr_conflict",  32'(conflict_cnt),  32'd0);
        chk("clr_cpu_grant", 32'(cpu_grant_cnt), 32'd0);
        chk("clr_ldr_grant", 32'(ldr_grant_cnt), 32'd0);
        @(posedge clk);
        #1;
`endif

        step(0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported synchronous data memory between two requesters:
  - the CPU data port (MemWrite / Mem_WrAddr / Mem_WrData / ReadData side);
  - a loader/debug master (program/data load over UART or test harness).
- Issues at most one memory access per cycle, using fair bounded-burst arbitration with an exclusive loader lock.
- Drives a stall to the CPU clock-enable logic when the CPU loses arbitration.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_gnt
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  access to CPU issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- ldr_req  in  1  loader request, level
- ldr_we  in  1  loader write enable
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_lock  in  1  loader exclusive ownership request
- ldr_gnt  out  1  access to loader issued this cycle
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  DW  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en & ~mem_we

Behaviour:
- State register: owner ∈ {IDLE, CPU, LDR}, burst_cnt (4 bits), locked flag, rd_pend_cpu, rd_pend_ldr.
- Reset (async): owner=IDLE, burst_cnt=0, locked=0, rd_pend_*=0. While reset is high, all gnt, rvalid, mem_en and mem_we outputs are 0; data outputs are don't-care but held at 0.
- Grant decision is combinational from registered state plus current requests. gnt_x, mem_en, mem_we, mem_addr and mem_wdata are driven in the same cycle from the winner's inputs. Exactly one of cpu_gnt/ldr_gnt is high when mem_en=1.
- Priority, first match wins:
  - locked=1: only the loader may win; cpu_gnt=0.
  - Only one requester active: it wins.
  - Both active, owner=CPU or LDR, burst_cnt < MAX_BURST: owner wins.
  - Both active, burst_cnt == MAX_BURST: non-owner wins.
  - Both active, owner=IDLE: loader wins.
- On grant: if the winner equals owner, burst_cnt += 1 (saturating at MAX_BURST). Otherwise owner=winner and burst_cnt=1.
- No request: owner=IDLE, burst_cnt=0.
- Lock:
  - locked is set on the cycle ldr_lock=1 is sampled and cleared when ldr_lock=0 is sampled.
  - The current cycle's grant is unaffected; the lock takes effect the following cycle.
  - While locked, cpu_stall follows cpu_req.
- Reads: rd_pend_x is set for one cycle after a read grant to x. x_rvalid = rd_pend_x, and x_rdata = mem_rdata, gated to 0 when rvalid=0.
- Writes: complete at the grant edge; no rvalid is produced.
- Back-to-back: a new grant is allowed while the previous read is returning. rvalid for grant N coincides with gnt N+1.
- Reset mid-read: the pending rvalid is dropped and not re-issued.
- mem_en=0 cycles hold mem_addr/mem_wdata at the last value (no glitch toggling).

Optional Feature:
- ARB_STATS_EN:
  - When defined, adds outputs cpu_grant_cnt[15:0], ldr_grant_cnt[15:0] and conflict_cnt[15:0].
  - conflict_cnt counts cycles with cpu_req & ldr_req.
  - All counters saturate at 16'hFFFF and are zeroed by reset, plus an added input stats_clr (synchronous clear, priority over increment).
- Undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- CPU only: cpu_req=1, read addr 0x10, mem returns 0xDEADBEEF → cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0 throughout.
- Both request continuously from IDLE, MAX_BURST=4 → grant sequence L,L,L,L,C,C,C,C,L…; cpu_stall=1 exactly on the L cycles.
- Loader asserts ldr_lock, writes 0x00..0x1C (8 words) while cpu_req held high → 8 ldr_gnt pulses, cpu_gnt=0 all cycles, and the first cpu_gnt occurs 1 cycle after ldr_lock is sampled low.
- Alternating reads C@0x4, L@0x8 on consecutive cycles → each rvalid arrives one cycle after its own gnt with the correct data and is never routed to the other requester.
- Assert reset one cycle after a CPU read grant → no cpu_rvalid, all outputs 0 during reset, owner=IDLE afterwards, and a fresh request is granted in the first cycle after reset release.
- ARB_STATS_EN: 10 cycles of both requesting, then stats_clr → conflict_cnt=10 and grant counts sum to 10, then all counters read 0 the next cycle.
